// File: rtl/yutorina_bus_arbiter_pkg.sv
// Shared configuration for the yutorina on-chip bus arbiter: master IDs,
// ID width, hold-limit defaults and the arbiter state encoding.
package yutorina_bus_arbiter_pkg;

  // Width of the encoded owner ID; fixed even when fewer masters are built.
  localparam int ID_W = 2;

  // Master IDs as wired inside yutorina_chip.
  localparam logic [ID_W-1:0] ID_IFETCH = 2'd0;
  localparam logic [ID_W-1:0] ID_DATA   = 2'd1;
  localparam logic [ID_W-1:0] ID_DMA    = 2'd2;
  localparam logic [ID_W-1:0] ID_DEBUG  = 2'd3;

  // Hold-limit defaults; HOLD_W must be wide enough to count to MAX_HOLD.
  localparam int MAX_HOLD_DEF = 16;
  localparam int HOLD_W_DEF   = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OWNED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/yutorina_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: scans the request vector starting at
// i_start and wrapping at N, returning the first requester found.
module yutorina_rr_pick
  import yutorina_bus_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]    i_req,
  input  logic [ID_W-1:0] i_start,
  output logic [N-1:0]    o_win,
  output logic [ID_W-1:0] o_win_id,
  output logic            o_found
);

  // First requester at or after the start pointer wins.
  always_comb begin
    // NOTE: every output gets a default before the search loop so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    o_win    = '0;
    o_win_id = '0;
    o_found  = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!o_found && (j == (int'(i_start) + i) % N) && i_req[j]) begin
          o_win[j] = 1'b1;
          o_win_id = ID_W'(j);
          o_found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin bus arbiter for up to four masters with a hold-time limit.
// Grant, owner ID, valid and preempt pulse are all registered.
module yutorina_bus_arbiter
  import yutorina_bus_arbiter_pkg::*;
#(
  parameter int N_MASTERS = 4,
  parameter int MAX_HOLD  = MAX_HOLD_DEF,
  parameter int HOLD_W    = HOLD_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] m_req,
  input  logic [N_MASTERS-1:0] m_busy,
  output logic [N_MASTERS-1:0] m_grnt,
  output logic [ID_W-1:0]      grnt_id,
  output logic                 grnt_vld,
  output logic                 preempt
);

  localparam logic [ID_W-1:0]   LAST_ID    = ID_W'(N_MASTERS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam bit                PREEMPT_EN = (MAX_HOLD > 0);

  arb_state_e            r_state,      w_state_nxt;
  logic [N_MASTERS-1:0]  r_grnt,       w_grnt_nxt;
  logic [ID_W-1:0]       r_grnt_id,    w_grnt_id_nxt;
  logic                  r_grnt_vld,   w_grnt_vld_nxt;
  logic                  r_preempt,    w_preempt_nxt;
  logic [ID_W-1:0]       r_last_owner, w_last_owner_nxt;
  logic [HOLD_W-1:0]     r_hold_cnt,   w_hold_cnt_nxt;

  logic [ID_W-1:0]       w_start;
  logic                  w_owner_req;
  logic                  w_owner_busy;
  logic [N_MASTERS-1:0]  w_others;
  logic [N_MASTERS-1:0]  w_win;
  logic [ID_W-1:0]       w_win_id;
  logic                  w_found;

  // Search starts just past the last owner, wrapping at N_MASTERS.
  assign w_start      = (r_last_owner == LAST_ID) ? '0 : r_last_owner + 1'b1;
  // The grant is one-hot (or zero), so masking picks out the owner's bits.
  assign w_owner_req  = |(m_req  & r_grnt);
  assign w_owner_busy = |(m_busy & r_grnt);
  // Owner's request is excluded from re-arbitration; in IDLE r_grnt is zero
  // so this is simply m_req.
  assign w_others     = m_req & ~r_grnt;

  yutorina_rr_pick #(
    .N (N_MASTERS)
  ) u_rr_pick (
    .i_req    (w_others),
    .i_start  (w_start),
    .o_win    (w_win),
    .o_win_id (w_win_id),
    .o_found  (w_found)
  );

  // Next-state and next-output logic for the IDLE/OWNED arbiter.
  always_comb begin
    w_state_nxt      = r_state;
    w_grnt_nxt       = r_grnt;
    w_grnt_id_nxt    = r_grnt_id;
    w_last_owner_nxt = r_last_owner;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_preempt_nxt    = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt      = ST_OWNED;
          w_grnt_nxt       = w_win;
          w_grnt_id_nxt    = w_win_id;
          w_last_owner_nxt = w_win_id;
          w_hold_cnt_nxt   = '0;
        end
      end

      ST_OWNED: begin
        if (!w_owner_req) begin
          // Voluntary release: hand over directly or fall back to IDLE.
          w_hold_cnt_nxt = '0;
          if (w_found) begin
            w_grnt_nxt       = w_win;
            w_grnt_id_nxt    = w_win_id;
            w_last_owner_nxt = w_win_id;
          end else begin
            w_state_nxt   = ST_IDLE;
            w_grnt_nxt    = '0;
            w_grnt_id_nxt = '0;
          end
        end else if (PREEMPT_EN && (r_hold_cnt == HOLD_MAX) && w_found &&
                     !w_owner_busy) begin
          // Hold limit reached with someone waiting: force a switch.
          w_grnt_nxt       = w_win;
          w_grnt_id_nxt    = w_win_id;
          w_last_owner_nxt = w_win_id;
          w_hold_cnt_nxt   = '0;
          w_preempt_nxt    = 1'b1;
        end else if (w_found && (r_hold_cnt != HOLD_MAX)) begin
          // Count only cycles in which another master is waiting.
          w_hold_cnt_nxt = r_hold_cnt + 1'b1;
        end
      end

      default: begin
        w_state_nxt   = ST_IDLE;
        w_grnt_nxt    = '0;
        w_grnt_id_nxt = '0;
      end
    endcase

    w_grnt_vld_nxt = |w_grnt_nxt;
  end

  // State and output registers; reset clears all grants asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: last owner resets to the top ID so master 0 is searched first.
      r_state      <= ST_IDLE;
      r_grnt       <= '0;
      r_grnt_id    <= '0;
      r_grnt_vld   <= 1'b0;
      r_preempt    <= 1'b0;
      r_last_owner <= LAST_ID;
      r_hold_cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      r_state      <= w_state_nxt;
      r_grnt       <= w_grnt_nxt;
      r_grnt_id    <= w_grnt_id_nxt;
      r_grnt_vld   <= w_grnt_vld_nxt;
      r_preempt    <= w_preempt_nxt;
      r_last_owner <= w_last_owner_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
    end
  end

  assign m_grnt   = r_grnt;
  assign grnt_id  = r_grnt_id;
  assign grnt_vld = r_grnt_vld;
  assign preempt  = r_preempt;

endmodule

// File: doc/yutorina_bus_arbiter.md
Name: yutorina_bus_arbiter

Overview:
- Round-robin arbiter that shares the on-chip bus inside yutorina_chip between up to four bus masters (instruction fetch, data access, DMA, debug).
- Produces a registered one-hot grant and an encoded owner ID for the chip's bus address/data multiplexers.
- Uses a hold-time limit so that one master cannot starve the others.
- Runs on the main clock from yutorina_clk_gen and is reset by chip_rst.

Parameters:
- N_MASTERS, 4, number of requesters; legal values 2..4; grant ID is always 2 bits wide.
- MAX_HOLD, 16, cycles an owner may keep the bus while another master waits; 0 disables preemption.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- m_req  in  N_MASTERS  bus request per master; a master holds it high for as long as it wants the bus.
- m_busy  in  N_MASTERS  master is mid-transaction and must not be preempted; only the current owner's bit is used.
- m_grnt  out  N_MASTERS  one-hot grant; registered.
- grnt_id  out  2  encoded ID of the current owner; registered.
- grnt_vld  out  1  some master owns the bus; registered.
- preempt  out  1  single-cycle pulse in the cycle a forced switch takes effect.

Behaviour:
- Reset (asynchronous assert while rst is low):
  - m_grnt=0, grnt_id=0, grnt_vld=0, preempt=0.
  - State IDLE, last_owner=N_MASTERS-1 so that master 0 has first priority, hold_cnt=0.
- States: IDLE and OWNED. All outputs are registered and change only on a clock edge.
- Priority order: search from (last_owner+1) mod N_MASTERS upward, wrapping at N_MASTERS.
- IDLE:
  - Any m_req bit high in cycle t → OWNED from t+1, with the winner's grant, grnt_vld=1 and grnt_id set.
  - Grant latency is exactly 1 cycle.
- OWNED, owner's m_req still high: grant is held and grnt_id is stable.
- OWNED, owner's m_req low in cycle t:
  - If any other request is high in t, the grant moves directly to the next round-robin winner at t+1. There is no idle gap.
  - Otherwise the next state is IDLE and m_grnt=0 at t+1.
  - The owner's request is ignored during this re-arbitration, so the same owner can only be picked again after a later cycle.
- hold_cnt:
  - Clears whenever ownership changes or the state goes to IDLE.
  - Increments each cycle in OWNED while any non-owner request is high.
  - Holds while no other master waits, and saturates at MAX_HOLD.
- Preemption (MAX_HOLD>0):
  - Condition: hold_cnt==MAX_HOLD, another request pending, owner's m_busy low, all in cycle t.
  - Action: the grant moves to the next winner at t+1 and preempt=1 for that one cycle.
  - If the owner's m_busy is high, preemption waits until the first cycle in which m_busy is low.
  - A preempted owner that still requests takes its normal round-robin turn later.
- Simultaneous events: if in the same cycle the owner drops m_req and the preemption condition is met, treat it as a normal release; preempt stays 0.
- Requests that drop before they are granted are simply not considered on the next evaluation.
- m_req bits at or above N_MASTERS do not exist; unused internal bits are tied to 0.
- Reset asserted mid-ownership removes all grants immediately (asynchronously). After release, arbitration restarts with master 0 priority.
- Invariant: m_grnt is zero or one-hot at all times, and grnt_vld equals the OR of m_grnt.

Decomposition:
- Shared package (global config header):
  - Master ID constants: IFETCH=0, DATA=1, DMA=2, DEBUG=3.
  - Width of the ID encoding (2).
  - Defaults for MAX_HOLD and HOLD_W.
  - The IDLE/OWNED state encoding.
- One sub-module: yutorina_rr_pick. It is purely combinational: from a request vector and a start pointer it returns a one-hot winner, its ID and a found flag. It is used for both the idle grant and the handover grant.

Test Plan:
- Reset, then m_req=0001 at cycle 2 → m_grnt=0001, grnt_id=0, grnt_vld=1 at cycle 3; assert rst low mid-grant → all outputs 0 immediately.
- From idle, m_req=1111 held with each master releasing 3 cycles after its grant → grant order 0,1,2,3,0; handovers have no idle cycle.
- Master 2 owns with MAX_HOLD=16 and m_req=0110 held, m_busy=0 → after 16 waiting cycles m_grnt goes 0100→0010 and preempt pulses for 1 cycle.
- Same as previous, but m_busy[2]=1 for 5 extra cycles → switch is deferred until the cycle after m_busy[2] falls; hold_cnt stays saturated at 16.
- Owner drops m_req in the same cycle the preemption condition is met → normal handover, preempt=0.
- Randomized m_req/m_busy for 10k cycles → m_grnt is always zero or one-hot, and no requester waits longer than (N_MASTERS-1)·(MAX_HOLD+max busy)+N_MASTERS cycles.
